// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the PIO input debouncer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package debounce_pkg;

    localparam int CLK_HZ                = 12000000;
    localparam int DEFAULT_DEBOUNCE_MS   = 10;
    localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEFAULT_DEBOUNCE_MS;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int width_for(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced channel: synchroniser chain, stability counter, level and edge registers.
// Latency: SYNC_STAGES + STABLE_CYCLES edges from a steady raw level to db.
// Backpressure: none; free-running input conditioner.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int               CNT_W    = width_for(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // High on the edge where the new level has survived its full window.
    assign accept = (sync != db) && (cnt == CNT_LAST);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cnt  <= '0;
            db   <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == db) begin
                cnt <= '0;
            end else if (accept) begin
                cnt  <= '0;
                db   <= sync;
                rise <= sync;
                fall <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_input_debouncer.sv
// Multi-channel raw-pin conditioner feeding the PIO input port plus edge pulses.
// Latency: SYNC_STAGES + STABLE_CYCLES edges per channel; pulses and changed aligned with db_out.
// Backpressure: none; every channel runs continuously and independently.
module pio_input_debouncer
    import debounce_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    logic [WIDTH-1:0] accept_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_BIT     (RESET_VALUE[i])
        ) u_bit (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .raw           (raw_in[i]),
            .db            (db_out[i]),
            .rise          (rise_pulse[i]),
            .fall          (fall_pulse[i]),
            .accept        (accept_vec[i])
        );
    end

    // Registered from the same next-state strobes that set the pulse flops.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |accept_vec;
        end
    end

endmodule

// File: doc/pio_input_debouncer.md
Name: pio_input_debouncer

Overview:
- Multi-channel input conditioner for raw board inputs (buttons, switches, header pins).
- Synchronises each bit into clk_clk, then debounces it with a per-bit stability counter.
- Drives the Nios PIO input port (pio1_export) with a clean, stable value.
- Also emits one-cycle rise, fall and any-change pulses for optional interrupt or LED logic.

Parameters:
- WIDTH, 8, number of input channels.
- SYNC_STAGES, 2, synchroniser flop depth; minimum 2.
- STABLE_CYCLES, 120000, consecutive cycles a new level must persist before it is accepted (10 ms at 12 MHz); minimum 1.
- RESET_VALUE, 0 (WIDTH bits), reset value of the synchroniser flops and db_out.

Ports:
- clk_clk  input  1  system clock; sole clock domain.
- reset_reset_n  input  1  synchronous, active-low reset.
- raw_in  input  WIDTH  asynchronous raw pin levels.
- db_out  output  WIDTH  debounced level; connects to pio1_export.
- rise_pulse  output  WIDTH  per bit, high for one cycle when db_out bit goes 0->1.
- fall_pulse  output  WIDTH  per bit, high for one cycle when db_out bit goes 1->0.
- changed  output  1  OR-reduction of rise_pulse and fall_pulse, registered in the same cycle as the pulses.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-low on reset_reset_n, sampled only on the rising edge of clk_clk.
- Values while reset_reset_n=0:
  - all synchroniser flops = RESET_VALUE
  - db_out = RESET_VALUE
  - all counters = 0
  - rise_pulse, fall_pulse and changed = 0
- Synchroniser: raw_in passes through SYNC_STAGES flops. Call the last stage sync[i].
- Per-bit counter cnt[i], width clog2(STABLE_CYCLES+1):
  - If sync[i] == db_out[i]: cnt[i] <= 0 (mismatch lost; a glitch is discarded).
  - If sync[i] != db_out[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If sync[i] != db_out[i] and cnt[i] == STABLE_CYCLES-1: on that edge db_out[i] <= sync[i], cnt[i] <= 0, and the matching rise or fall bit is set for exactly one cycle.
- Latency: a raw_in level held steady from before edge 1 appears on db_out after edge SYNC_STAGES+STABLE_CYCLES. Default is 120002 cycles.
- Glitch rejection: any mismatch shorter than STABLE_CYCLES cycles at sync[i] causes no db_out change and no pulse.
- Bouncing input: every return to the current db_out level restarts the count from 0.
- Channels are fully independent. Simultaneous events on several bits update in the same cycle with multiple pulse bits set.
- rise_pulse and fall_pulse are never set together for the same bit. Pulses are never set during reset.
- Reset mid-count: counts are discarded. After release the full latency applies again.
- Startup: if raw_in differs from RESET_VALUE at reset release, db_out converges after the full latency and generates the corresponding pulses.
- No combinational path from raw_in to any output. All outputs are registered.
- Counter never wraps: the maximum value reached is STABLE_CYCLES-1.

Decomposition:
- Shared package debounce_pkg:
  - clog2 width helper function
  - CLK_HZ constant = 12000000
  - DEFAULT_DEBOUNCE_MS = 10
  - derived default STABLE_CYCLES
- One natural sub-module, debounce_bit: one synchroniser chain, one counter, db/rise/fall registers.
- Top level instantiates WIDTH copies via generate and ORs the pulses into changed.

Test Plan (bench uses SYNC_STAGES=2, STABLE_CYCLES=4, RESET_VALUE=0):
- Reset hold: reset_reset_n=0 for 5 cycles with raw_in=8'hFF -> db_out=8'h00, all pulses 0. Release with raw_in=8'h00 -> db_out stays 8'h00 and no pulses for 20 cycles.
- Clean edge: raw_in 8'h00->8'h01 held -> db_out=8'h01 after exactly 6 edges; rise_pulse=8'h01 and changed=1 for that single cycle only.
- Glitch: raw_in[3] high for 3 cycles, then low -> db_out unchanged at 8'h00, no pulses over 20 cycles.
- Bounce: raw_in[5] toggles every 2 cycles for 10 cycles, then stays 1 -> db_out[5]=1 exactly 6 edges after the last transition, one rise pulse total.
- Simultaneous: from db_out=8'h80, raw_in changes to 8'h01 in one cycle -> after 6 edges db_out=8'h01, rise_pulse=8'h01, fall_pulse=8'h80, changed=1, all in one cycle.
- Reset mid-count: raw_in[0]=1, reset asserted when cnt=3 for 1 cycle -> no pulse. After release db_out[0]=1 after the full 6 edges.
